// File: rtl/ldpc_core.sv
// ldpc_core: layered min-sum decoder for quasi-cyclic LDPC codes.
// One base-matrix row (layer) is processed per enabled clock, followed by one syndrome
// check cycle per iteration. Decoding stops on a zero syndrome or at the iteration limit.
module ldpc_core #(
  parameter int C      = 12,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int N      = 6,
  parameter int data_w = 6,
  parameter int mtx_w  = 8
) (
  input  logic                  en,
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R*D*data_w-1:0] l,
  input  logic [C*R*mtx_w-1:0]  m,
  output logic [R*D-1:0]        s,
  output logic                  term
);
  localparam int PW   = data_w + 2;
  localparam int V    = R * D;
  localparam int LW   = $clog2(C + 1);
  localparam int IW   = $clog2(N + 1);
  localparam int PMAX = 2 ** (PW - 1) - 1;
  localparam int RMAX = 2 ** (data_w - 1) - 1;

  typedef enum logic [1:0] {StIdle, StDecode, StCheck, StDone} state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           layer_q, layer_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic [V-1:0]            s_q, s_d;
  logic [V*PW-1:0]         p_q, p_d;  // posterior of variable v at [v*PW +: PW]
  logic [C*D*R*data_w-1:0] r_q, r_d;  // check message (c,k,j) at [((c*D+k)*R+j)*data_w +: data_w]
  logic                    syn_nz;

  // Symmetric saturation to [-lim, lim].
  function automatic int sat(input int x, input int lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  // Signed base-matrix entry (c,j); negative means a zero block.
  function automatic int shift_at(input logic [C*R*mtx_w-1:0] mm, input int c, input int j);
    logic signed [mtx_w-1:0] e;
    e = mm[(C*R-1-(c*R+j))*mtx_w +: mtx_w];
    return int'(e);
  endfunction

  // Datapath: channel load in IDLE, one min-sum layer update per DECODE cycle.
  always_comb begin
    logic signed [data_w-1:0] lraw;
    logic signed [PW-1:0]     praw;
    logic signed [data_w-1:0] rraw;
    int lv, sh, idx, c, a, mag, rn, pn, min1, min2, pos1;
    logic par, neg;
    logic conn [R];
    int   vix [R];
    int   q [R];
    p_d  = p_q;
    r_d  = r_q;
    s_d  = s_q;
    lraw = '0;
    praw = '0;
    rraw = '0;
    lv = 0; sh = 0; idx = 0; c = 0; a = 0; mag = 0; rn = 0; pn = 0;
    min1 = 0; min2 = 0; pos1 = 0;
    par = 1'b0;
    neg = 1'b0;
    for (int j = 0; j < R; j++) begin
      conn[j] = 1'b0;
      vix[j]  = 0;
      q[j]    = 0;
    end
    if (state_q == StIdle && en) begin
      for (int v = 0; v < V; v++) begin
        lraw = l[(V-1-v)*data_w +: data_w];
        lv   = int'(lraw);
        if (lv < -RMAX) lv = -RMAX;  // keep the channel range symmetric
        p_d[v*PW +: PW] = PW'(lv);
      end
      r_d = '0;
    end else if (state_q == StDecode && en) begin
      c = int'(layer_q);
      for (int k = 0; k < D; k++) begin
        min1 = PMAX;
        min2 = PMAX;
        pos1 = -1;
        par  = 1'b0;
        for (int j = 0; j < R; j++) begin
          sh      = shift_at(m, c, j);
          conn[j] = (sh >= 0);
          if (conn[j]) begin
            idx    = (k + sh) % D;
            vix[j] = j * D + idx;
            praw   = p_q[vix[j]*PW +: PW];
            rraw   = r_q[((c*D+k)*R+j)*data_w +: data_w];
            q[j]   = sat(int'(praw) - int'(rraw), PMAX);
            a      = (q[j] < 0) ? -q[j] : q[j];
            if (a < min1) begin
              min2 = min1;
              min1 = a;
              pos1 = j;
            end else if (a < min2) begin
              min2 = a;
            end
            if (q[j] < 0) par = ~par;
          end
        end
        for (int j = 0; j < R; j++) begin
          if (conn[j]) begin
            // Excluding this input: the minimum is min2 only where this input was min1.
            mag = (j == pos1) ? min2 : min1;
            if (mag > RMAX) mag = RMAX;
            neg = par ^ (q[j] < 0);
            rn  = neg ? -mag : mag;
            pn  = sat(q[j] + rn, PMAX);
            r_d[((c*D+k)*R+j)*data_w +: data_w] = data_w'(rn);
            p_d[vix[j]*PW +: PW] = PW'(pn);
            s_d[V-1-vix[j]] = (pn < 0);
          end
        end
      end
    end
  end

  // Syndrome of the current hard decisions against the whole base matrix.
  always_comb begin
    int   sh, v;
    logic bit_x;
    syn_nz = 1'b0;
    sh = 0;
    v  = 0;
    bit_x = 1'b0;
    for (int c = 0; c < C; c++) begin
      for (int k = 0; k < D; k++) begin
        bit_x = 1'b0;
        for (int j = 0; j < R; j++) begin
          sh = shift_at(m, c, j);
          if (sh >= 0) begin
            v     = j * D + (k + sh) % D;
            bit_x = bit_x ^ s_q[V-1-v];
          end
        end
        syn_nz = syn_nz | bit_x;
      end
    end
  end

  // Control FSM: layer sequencing, iteration count and termination.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    iter_d  = iter_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StDecode;
          layer_d = '0;
          iter_d  = '0;
        end
      end
      StDecode: begin
        if (en) begin
          if (layer_q == LW'(C - 1)) begin
            layer_d = '0;
            state_d = StCheck;
          end else begin
            layer_d = layer_q + LW'(1);
          end
        end
      end
      StCheck: begin
        if (en) begin
          if (!syn_nz || (int'(iter_q) + 1 == N)) begin
            state_d = StDone;
          end else begin
            iter_d  = iter_q + IW'(1);
            layer_d = '0;
            state_d = StDecode;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase
  end

  // State and memory registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      layer_q <= '0;
      iter_q  <= '0;
      s_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      iter_q  <= iter_d;
      s_q     <= s_d;
      p_q     <= p_d;
      r_q     <= r_d;
    end
  end

  assign s    = s_q;
  assign term = (state_q == StDone);

endmodule

// File: tb/tb_ldpc_core.sv
// tb_ldpc_core: scoreboard bench for ldpc_core (default code, a tiny code, and N=1).
module tb_ldpc_core;
  localparam int BC = 12;
  localparam int BR = 24;
  localparam int BD = 96;
  localparam int BV = BR * BD;
  localparam int DW = 6;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              en_b, en_s, en_n;
  logic [BV*DW-1:0]  l_b, l_n;
  logic [BC*BR*MW-1:0] m_b;
  logic [12*DW-1:0]  l_s;
  logic [3*MW-1:0]   m_s;
  logic [BV-1:0]     s_b, s_n;
  logic [11:0]       s_s;
  logic              term_b, term_s, term_n;

  ldpc_core u_big (
    .en(en_b), .clk(clk), .rst(rst), .l(l_b), .m(m_b), .s(s_b), .term(term_b)
  );

  ldpc_core #(.C(1), .R(3), .D(4)) u_small (
    .en(en_s), .clk(clk), .rst(rst), .l(l_s), .m(m_s), .s(s_s), .term(term_s)
  );

  ldpc_core #(.N(1)) u_n1 (
    .en(en_n), .clk(clk), .rst(rst), .l(l_n), .m(m_b), .s(s_n), .term(term_n)
  );

  // 12x24 rate-1/2 base matrix, lifting 96.
  int base_m [BC][BR] = '{
    '{-1,94,73,-1,-1,-1,-1,-1,55,83,-1,-1, 7, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1},
    '{-1,27,-1,-1,-1,22,79, 9,-1,-1,-1,12,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1},
    '{-1,-1,-1,24,22,81,-1,33,-1,-1,-1, 0,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1},
    '{61,-1,47,-1,-1,-1,-1,-1,65,25,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1},
    '{-1,-1,39,-1,-1,-1,84,-1,-1,41,72,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1},
    '{-1,-1,-1,-1,46,40,-1,82,-1,-1,-1,79, 0,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1},
    '{-1,-1,95,53,-1,-1,-1,-1,-1,14,18,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1},
    '{-1,11,73,-1,-1,-1, 2,-1,-1,47,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1},
    '{12,-1,-1,-1,83,24,-1,43,-1,-1,-1,51,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1},
    '{-1,-1,-1,-1,-1,94,-1,59,-1,-1,70,72,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1},
    '{-1,-1, 7,65,-1,-1,-1,-1,39,49,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0},
    '{43,-1,-1,-1,-1,66,-1,41,-1,-1,-1,26, 7,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0}
  };

  typedef struct {
    string         tag;
    int            lat;
    logic [BV-1:0] s;
    bit            chk_s;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   sel     = 0;

  logic          term_m;
  logic [BV-1:0] s_m;

  always_comb begin
    case (sel)
      1: begin term_m = term_s; s_m = BV'(s_s); end
      2: begin term_m = term_n; s_m = s_n; end
      default: begin term_m = term_b; s_m = s_b; end
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_en(input int which, input logic v);
    case (which)
      1:       en_s = v;
      2:       en_n = v;
      default: en_b = v;
    endcase
  endtask

  task automatic push_exp(input string tag, input int lat, input logic [BV-1:0] s, input bit cs);
    exp_t e;
    e.tag = tag;
    e.lat = lat;
    e.s = s;
    e.chk_s = cs;
    sb_q.push_back(e);
  endtask

  task automatic fill_b(input int val);
    for (int v = 0; v < BV; v++) l_b[(BV-1-v)*DW +: DW] = DW'(val);
  endtask

  // Pulse reset; returns at a falling edge with every enable low.
  task automatic do_reset();
    @(negedge clk);
    en_b = 1'b0; en_s = 1'b0; en_n = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise en at a falling edge, count edges after the load edge until term, then score.
  task automatic run_decode(input int which, input int stall_at, input int stall_len);
    int   cyc;
    bit   seen;
    exp_t e;
    sel = which;
    set_en(which, 1'b1);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (term_m) seen = 1'b1;
      if (stall_len > 0 && cyc == stall_at) set_en(which, 1'b0);
      if (stall_len > 0 && cyc == stall_at + stall_len) set_en(which, 1'b1);
    end
    chk("sb_nonempty", int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_lat"}, seen ? cyc : -1, e.lat);
      if (e.chk_s) chk({e.tag, "_s_diff"}, $countones(s_m ^ e.s), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    en_b = 1'b0; en_s = 1'b0; en_n = 1'b0;
    m_s  = '0;
    l_s  = '0;
    l_n  = '0;
    for (int c = 0; c < BC; c++)
      for (int j = 0; j < BR; j++)
        m_b[(BC*BR-1-(c*BR+j))*MW +: MW] = MW'(base_m[c][j]);
    fill_b(10);
    #5;
    chk("rst_term_b", int'(term_b), 0);
    chk("rst_s_b", $countones(s_b), 0);
    chk("rst_term_s", int'(term_s), 0);
    #5 rst = 1'b0;

    // Idle with en low: nothing happens.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_term", int'(term_b), 0);
      chk("idle_s", $countones(s_b), 0);
    end

    // Clean all-positive word: one iteration.
    push_exp("clean", 13, '0, 1'b1);
    run_decode(0, -1, 0);
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_hold_term", int'(term_b), 1);
    chk("done_hold_s", $countones(s_b), 0);

    // Two weak errors corrected in the first iteration.
    do_reset();
    fill_b(20);
    l_b[(BV-1-0)*DW +: DW]   = DW'(-5);
    l_b[(BV-1-100)*DW +: DW] = DW'(-3);
    push_exp("two_err", 13, '0, 1'b1);
    run_decode(0, -1, 0);

    // Stall of 5 cycles mid-decode stretches latency by 5.
    do_reset();
    fill_b(10);
    push_exp("stall", 18, '0, 1'b1);
    run_decode(0, 4, 5);

    // Reset five layers into a decode of an all-negative word.
    do_reset();
    fill_b(-10);
    sel  = 0;
    en_b = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_s_nonzero", int'(s_b != '0), 1);
    chk("mid_term", int'(term_b), 0);
    rst = 1'b1;
    #1;
    chk("async_term", int'(term_b), 0);
    chk("async_s", $countones(s_b), 0);
    @(negedge clk);
    en_b = 1'b0;
    rst  = 1'b0;
    fill_b(10);
    push_exp("after_rst", 13, '0, 1'b1);
    run_decode(0, -1, 0);

    // Tiny code: vars 0..7 negative, 8..11 positive.
    do_reset();
    for (int v = 0; v < 12; v++) l_s[(11-v)*DW +: DW] = DW'((v < 8) ? -20 : 20);
    push_exp("small", 2, BV'(12'hFF0), 1'b1);
    run_decode(1, -1, 0);

    // Single-iteration limit with a noisy word.
    do_reset();
    for (int v = 0; v < BV; v++) l_n[(BV-1-v)*DW +: DW] = DW'((v % 2 == 0) ? 3 : -3);
    push_exp("n1", 13, '0, 1'b0);
    run_decode(2, -1, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
